alu_sequencer: RTL

Multi-cycle controller wrapped around the miniSRC ALU operations. Accepts one operation at a time through a start/busy/done handshake, executes logic, add/sub, shift and rotate ops in one cycle, and sequences iterative radix-2 Booth multiply and restoring signed divide over W cycles. The 64-bit result is delivered as HI/LO halves for the datapath's HI and LO registers.

---
 rtl/alu_sequencer.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU controller: single-cycle logic/arith/shift ops, Booth multiply, restoring divide.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise op=4 reports err.
module alu_sequencer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         dz,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CW = $clog2(W + 1);

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] OP_DIV = 4'd4;
`endif
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_ROR = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_AND = 4'd9;
    localparam logic [3:0] OP_OR  = 4'd10;
    localparam logic [3:0] OP_NEG = 4'd11;
    localparam logic [3:0] OP_NOT = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
`ifdef ALU_SEQ_DIV_EN
        S_DIV,
`endif
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  mcand_q, mcand_d;
    logic [W:0]    acc_q, acc_d;
    logic [W-1:0]  q_q, q_d;
    logic          qm1_q, qm1_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic          err_q, err_d;
    logic          dz_q, dz_d;
`ifdef ALU_SEQ_DIV_EN
    logic          neg_quo_q, neg_quo_d;
    logic          neg_rem_q, neg_rem_d;
`endif

    logic [W-1:0]   alu_res;
    logic           alu_ill;
    logic [4:0]     amt;
    logic [2*W-1:0] rot_r, rot_l;

    // Single-cycle datapath works straight from the input operands at the accept edge.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        amt     = b[4:0];
        rot_r   = {a, a} >> amt;
        rot_l   = {a, a} << amt;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SHR:  alu_res = a >> amt;
            OP_SHL:  alu_res = a << amt;
            OP_ROR:  alu_res = rot_r[W-1:0];
            OP_ROL:  alu_res = rot_l[2*W-1:W];
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NEG:  alu_res = '0 - a;
            OP_NOT:  alu_res = ~a;
            default: alu_ill = 1'b1;
        endcase
    end

    // The accumulator carries one guard bit so subtracting the most negative multiplicand cannot overflow.
    logic [W:0]   m_ext;
    logic [W:0]   booth_sum;
    logic [W:0]   booth_acc;
    logic [W-1:0] booth_q;

    always_comb begin
        m_ext = {mcand_q[W-1], mcand_q};
        case ({q_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_ext;
            2'b10:   booth_sum = acc_q - m_ext;
            default: booth_sum = acc_q;
        endcase
        booth_acc = {booth_sum[W], booth_sum[W:1]};
        booth_q   = {booth_sum[0], q_q[W-1:1]};
    end

`ifdef ALU_SEQ_DIV_EN
    logic [W:0]   div_tmp;
    logic         div_ge;
    logic [W:0]   div_rem;
    logic [W-1:0] div_rem_w;
    logic [W-1:0] div_quo;

    always_comb begin
        div_tmp   = {acc_q[W-1:0], q_q[W-1]};
        div_ge    = (div_tmp >= {1'b0, mcand_q});
        div_rem   = div_ge ? (div_tmp - {1'b0, mcand_q}) : div_tmp;
        div_rem_w = div_rem[W-1:0];
        div_quo   = {q_q[W-2:0], div_ge};
    end
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;
        dz_d    = dz_q;
`ifdef ALU_SEQ_DIV_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    dz_d  = 1'b0;
                    if (op == OP_MUL) begin
                        mcand_d = a;
                        q_d     = b;
                        acc_d   = '0;
                        qm1_d   = 1'b0;
                        count_d = CW'(W);
                        state_d = S_MUL;
                    end
`ifdef ALU_SEQ_DIV_EN
                    else if (op == OP_DIV) begin
                        if (b == '0) begin
                            lo_d    = '1;
                            hi_d    = a;
                            dz_d    = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            mcand_d   = b[W-1] ? ('0 - b) : b;
                            q_d       = a[W-1] ? ('0 - a) : a;
                            acc_d     = '0;
                            neg_quo_d = a[W-1] ^ b[W-1];
                            neg_rem_d = a[W-1];
                            count_d   = CW'(W);
                            state_d   = S_DIV;
                        end
                    end
`endif
                    else begin
                        lo_d    = alu_res;
                        hi_d    = '0;
                        err_d   = alu_ill;
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: begin
                acc_d   = booth_acc;
                q_d     = booth_q;
                qm1_d   = q_q[0];
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    hi_d    = booth_acc[W-1:0];
                    lo_d    = booth_q;
                    state_d = S_DONE;
                end
            end
`ifdef ALU_SEQ_DIV_EN
            S_DIV: begin
                acc_d   = div_rem;
                q_d     = div_quo;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    lo_d    = neg_quo_q ? ('0 - div_quo) : div_quo;
                    hi_d    = neg_rem_q ? ('0 - div_rem_w) : div_rem_w;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            count_q <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
            dz_q    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
            dz_q    <= dz_d;
`ifdef ALU_SEQ_DIV_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

`ifdef ALU_SEQ_DIV_EN
    assign busy = (state_q == S_MUL) || (state_q == S_DIV);
`else
    assign busy = (state_q == S_MUL);
`endif
    assign done = (state_q == S_DONE);
    assign err  = err_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
